// File: rtl/divisor_arbitro_if.sv
// -----------------------------------------------------------------------------
// divisor_arbitro_if
// Bus between the arbiter and the single shared signed sequential divider
// (Divisor_Algoritmico). Start/Done handshake with operands and results.
//
//   Div_Start  arbiter -> divider  one-cycle start pulse
//   Div_Num    arbiter -> divider  numerator, stable for the whole operation
//   Div_Den    arbiter -> divider  denominator, stable for the whole operation
//   Div_Coc    divider -> arbiter  quotient
//   Div_Res    divider -> arbiter  remainder
//   Div_Done   divider -> arbiter  result valid
//
// Modports: master = arbiter side, slave = divider side.
// -----------------------------------------------------------------------------
interface divisor_arbitro_if #(
    parameter int tamanyo = 32
);
    logic               Div_Start;
    logic [tamanyo-1:0] Div_Num;
    logic [tamanyo-1:0] Div_Den;
    logic [tamanyo-1:0] Div_Coc;
    logic [tamanyo-1:0] Div_Res;
    logic               Div_Done;

    modport master (
        output Div_Start, Div_Num, Div_Den,
        input  Div_Coc, Div_Res, Div_Done
    );

    modport slave (
        input  Div_Start, Div_Num, Div_Den,
        output Div_Coc, Div_Res, Div_Done
    );
endinterface

// File: rtl/divisor_arbitro.sv
// -----------------------------------------------------------------------------
// divisor_arbitro
// Round-robin arbiter/sequencer sharing one signed sequential divider between
// N_REQ requesters. One request is latched, the divider is started with stable
// operands, Done is awaited under a watchdog, and quotient/remainder are
// returned with a one-cycle one-hot Ack. Division by zero is answered locally
// without starting the divider.
//
// Ports:
//   CLK       clock, rising edge
//   RST       synchronous active-high reset
//   Req       per-requester request level, held until its Ack
//   Num_in    packed numerators,   requester i at [i*tamanyo +: tamanyo]
//   Den_in    packed denominators, same packing
//   Ack       one-hot one-cycle acknowledge; results valid in that cycle
//   Coc_out   quotient
//   Res_out   remainder
//   Err_dz    division by zero (with Ack)
//   Err_to    divider timeout (with Ack)
//   Busy      high in every state except IDLE
//   Grant_id  index of the requester being served
//   div       divider bus (master side)
// -----------------------------------------------------------------------------
module divisor_arbitro #(
    parameter int tamanyo  = 32,
    parameter int N_REQ    = 4,
    parameter int WDOG_CYC = 104
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [N_REQ-1:0]           Req,
    input  logic [N_REQ*tamanyo-1:0]   Num_in,
    input  logic [N_REQ*tamanyo-1:0]   Den_in,
    output logic [N_REQ-1:0]           Ack,
    output logic [tamanyo-1:0]         Coc_out,
    output logic [tamanyo-1:0]         Res_out,
    output logic                       Err_dz,
    output logic                       Err_to,
    output logic                       Busy,
    output logic [$clog2(N_REQ)-1:0]   Grant_id,
    divisor_arbitro_if.master          div
);

    localparam int GW   = $clog2(N_REQ);
    localparam int WD_W = $clog2(WDOG_CYC + 1);
    localparam logic [N_REQ-1:0] ONE_HOT = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state;
    logic [GW-1:0]     last;
    logic [WD_W-1:0]   wdog;

    // Unpacked views of the packed operand buses, indexed by requester.
    logic [tamanyo-1:0] num_arr [N_REQ];
    logic [tamanyo-1:0] den_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign num_arr[g] = Num_in[g*tamanyo +: tamanyo];
        assign den_arr[g] = Den_in[g*tamanyo +: tamanyo];
    end

    // Round-robin pick: first set Req bit scanning from last+1, wrapping.
    logic              pick_valid;
    logic [GW-1:0]     pick_idx;
    logic [GW-1:0]     scan_idx;
    logic [tamanyo-1:0] sel_num;
    logic [tamanyo-1:0] sel_den;

    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            scan_idx = GW'((int'(last) + k) % N_REQ);
            if (!pick_valid && Req[scan_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = scan_idx;
            end
        end
        sel_num = num_arr[pick_idx];
        sel_den = den_arr[pick_idx];
    end

    // NOTE: all state and outputs are updated with non-blocking assignments so
    // every register samples values from before the edge, independent of
    // statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            last          <= GW'(N_REQ - 1);
            wdog          <= '0;
            Ack           <= '0;
            Coc_out       <= '0;
            Res_out       <= '0;
            Err_dz        <= 1'b0;
            Err_to        <= 1'b0;
            Busy          <= 1'b0;
            Grant_id      <= '0;
            div.Div_Start <= 1'b0;
            div.Div_Num   <= '0;
            div.Div_Den   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        Grant_id    <= pick_idx;
                        div.Div_Num <= sel_num;
                        div.Div_Den <= sel_den;
                        Busy        <= 1'b1;
                        if (sel_den == '0) begin
                            // Answered locally; the divider is never started.
                            state   <= RESP;
                            Ack     <= ONE_HOT << pick_idx;
                            Err_dz  <= 1'b1;
                            Err_to  <= 1'b0;
                            Coc_out <= '0;
                            Res_out <= '0;
                        end else begin
                            state         <= ISSUE;
                            div.Div_Start <= 1'b1;
                        end
                    end
                end

                ISSUE: begin
                    div.Div_Start <= 1'b0;
                    wdog          <= WD_W'(WDOG_CYC);
                    state         <= WAIT;
                end

                WAIT: begin
                    // Done is checked first so it wins over a same-cycle expiry.
                    if (div.Div_Done) begin
                        state   <= RESP;
                        Ack     <= ONE_HOT << Grant_id;
                        Coc_out <= div.Div_Coc;
                        Res_out <= div.Div_Res;
                        Err_dz  <= 1'b0;
                        Err_to  <= 1'b0;
                    end else begin
                        wdog <= wdog - 1'b1;
                        if (wdog <= WD_W'(1)) begin
                            state   <= RESP;
                            Ack     <= ONE_HOT << Grant_id;
                            Coc_out <= '0;
                            Res_out <= '0;
                            Err_dz  <= 1'b0;
                            Err_to  <= 1'b1;
                        end
                    end
                end

                RESP: begin
                    Ack    <= '0;
                    Err_dz <= 1'b0;
                    Err_to <= 1'b0;
                    Busy   <= 1'b0;
                    last   <= Grant_id;
                    state  <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
